// File: rtl/line_window_cache.sv
// line_window_cache
// Captures GBA scanlines (RGB555) into a 4-line ring buffer. Each pixel is
// expanded to RGB888 when it is written. The block serves a registered 3x3
// neighbourhood around the pixel that the HDMI image generator asks for.
// It also runs the read-line advance handshake and flags writer overrun.
//
// Ports
//   pxlClk        pixel clock (only clock)
//   rst           async active-low reset
//   wrEn/wrAddr/wrData   pixel write into the current write line
//   wrLineDone    pulse: write line complete
//   newFrameIn    pulse: frame start; resets write/read line counters
//   curPxl        read pixel index
//   nextLine      pulse: request read window advance
//   cacheUpdate   pulse: end of output line; commits a pending advance
//   sameLine      1 = advance not possible, generator repeats line
//   {prev,cur,next}Line{Prev,Cur,Next}Pxl{Red,Green,Blue}  3x3 RGB888 window
//   overrun       sticky: writer reused a buffer still in the read window
module line_window_cache #(
   parameter int LINE_W = 240,
   parameter int LINE_H = 160,
   parameter int NBUF   = 4
) (
   input  logic        pxlClk,
   input  logic        rst,
   input  logic        wrEn,
   input  logic [7:0]  wrAddr,
   input  logic [14:0] wrData,
   input  logic        wrLineDone,
   input  logic        newFrameIn,
   input  logic [7:0]  curPxl,
   input  logic        nextLine,
   input  logic        cacheUpdate,
   output logic        sameLine,
   output logic [7:0]  prevLinePrevPxlRed, prevLinePrevPxlGreen, prevLinePrevPxlBlue,
   output logic [7:0]  prevLineCurPxlRed,  prevLineCurPxlGreen,  prevLineCurPxlBlue,
   output logic [7:0]  prevLineNextPxlRed, prevLineNextPxlGreen, prevLineNextPxlBlue,
   output logic [7:0]  curLinePrevPxlRed,  curLinePrevPxlGreen,  curLinePrevPxlBlue,
   output logic [7:0]  curLineCurPxlRed,   curLineCurPxlGreen,   curLineCurPxlBlue,
   output logic [7:0]  curLineNextPxlRed,  curLineNextPxlGreen,  curLineNextPxlBlue,
   output logic [7:0]  nextLinePrevPxlRed, nextLinePrevPxlGreen, nextLinePrevPxlBlue,
   output logic [7:0]  nextLineCurPxlRed,  nextLineCurPxlGreen,  nextLineCurPxlBlue,
   output logic [7:0]  nextLineNextPxlRed, nextLineNextPxlGreen, nextLineNextPxlBlue,
   output logic        overrun
);
   localparam logic [7:0] LINE_W_C  = 8'(LINE_W);
   localparam logic [7:0] LAST_PX   = 8'(LINE_W - 1);
   localparam logic [7:0] LINE_H_C  = 8'(LINE_H);
   localparam logic [7:0] LAST_LINE = 8'(LINE_H - 1);

   // Expand each channel to 8 bits by replicating its top bits into the LSBs.
   function automatic logic [23:0] expand(input logic [14:0] p);
      return {p[14:10], p[14:12], p[9:5], p[9:7], p[4:0], p[4:2]};
   endfunction

   logic [23:0] ram [NBUF][LINE_W];

   logic [7:0] wr_line, lines_done, rd_line;
   logic       adv_pending;
   logic [7:0] wr_line_n, lines_done_n, rd_line_n;
   logic       adv_n, same_n;
   logic [8:0] need_n;

   // Write side. The RAM has no reset, so its contents are undefined after reset.
   always_ff @(posedge pxlClk) begin
      if (wrEn && wrAddr < LINE_W_C)
         ram[wr_line[1:0]][wrAddr] <= expand(wrData);
   end

   // Next-state values for the line counters and the handshake.
   always_comb begin
      wr_line_n    = wr_line;
      lines_done_n = lines_done;
      rd_line_n    = rd_line;
      adv_n        = adv_pending;
      if (newFrameIn) begin
         wr_line_n    = '0;
         lines_done_n = '0;
         rd_line_n    = '0;
         adv_n        = 1'b0;
      end else begin
         if (wrLineDone) begin
            lines_done_n = wr_line + 8'd1;
            wr_line_n    = (wr_line == LINE_H_C) ? wr_line : wr_line + 8'd1;
         end
         // A nextLine in the same cycle as cacheUpdate still counts. Any
         // cacheUpdate ends the request, whether it commits or drops it.
         if (cacheUpdate) begin
            if ((adv_pending || nextLine) && !sameLine)
               rd_line_n = rd_line + 8'd1;
            adv_n = 1'b0;
         end else if (nextLine) begin
            adv_n = 1'b1;
         end
      end
      // sameLine is taken from the post-edge state. The flag therefore always
      // matches the line counters currently held.
      need_n = ({1'b0, rd_line_n} + 9'd3 > {1'b0, LINE_H_C}) ? {1'b0, LINE_H_C}
                                                              : {1'b0, rd_line_n} + 9'd3;
      same_n = (rd_line_n == LAST_LINE) || ({1'b0, lines_done_n} < need_n);
   end

   always_ff @(posedge pxlClk or negedge rst) begin
      if (!rst) begin
         wr_line     <= '0;
         lines_done  <= '0;
         rd_line     <= '0;
         adv_pending <= 1'b0;
         sameLine    <= 1'b1;
         overrun     <= 1'b0;
      end else begin
         wr_line     <= wr_line_n;
         lines_done  <= lines_done_n;
         rd_line     <= rd_line_n;
         adv_pending <= adv_n;
         sameLine    <= same_n;
         if (wrLineDone && !newFrameIn && ({1'b0, wr_line} > {1'b0, rd_line} + 9'd2))
            overrun <= 1'b1;
      end
   end

   // Window addressing. Row 0/1/2 = prev/cur/next line, column 0/1/2 = prev/cur/next pixel.
   // Rows are buffer indices (line mod 4), clamped at the frame top and bottom.
   logic [2:0][1:0] row_buf;
   logic [2:0][7:0] col_addr;

   always_comb begin
      row_buf[0] = (rd_line == 8'd0)      ? rd_line[1:0] : rd_line[1:0] - 2'd1;
      row_buf[1] = rd_line[1:0];
      row_buf[2] = (rd_line == LAST_LINE) ? rd_line[1:0] : rd_line[1:0] + 2'd1;
      if (curPxl >= LINE_W_C) begin
         col_addr = {3{LAST_PX}};
      end else begin
         col_addr[0] = (curPxl == 8'd0)    ? curPxl : curPxl - 8'd1;
         col_addr[1] = curPxl;
         col_addr[2] = (curPxl >= LAST_PX) ? curPxl : curPxl + 8'd1;
      end
   end

   logic [2:0][2:0][23:0] win_q;

   always_ff @(posedge pxlClk or negedge rst) begin
      if (!rst) begin
         win_q <= '0;
      end else begin
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               win_q[r][c] <= ram[row_buf[r]][col_addr[c]];
      end
   end

   assign {prevLinePrevPxlRed, prevLinePrevPxlGreen, prevLinePrevPxlBlue} = win_q[0][0];
   assign {prevLineCurPxlRed,  prevLineCurPxlGreen,  prevLineCurPxlBlue}  = win_q[0][1];
   assign {prevLineNextPxlRed, prevLineNextPxlGreen, prevLineNextPxlBlue} = win_q[0][2];
   assign {curLinePrevPxlRed,  curLinePrevPxlGreen,  curLinePrevPxlBlue}  = win_q[1][0];
   assign {curLineCurPxlRed,   curLineCurPxlGreen,   curLineCurPxlBlue}   = win_q[1][1];
   assign {curLineNextPxlRed,  curLineNextPxlGreen,  curLineNextPxlBlue}  = win_q[1][2];
   assign {nextLinePrevPxlRed, nextLinePrevPxlGreen, nextLinePrevPxlBlue} = win_q[2][0];
   assign {nextLineCurPxlRed,  nextLineCurPxlGreen,  nextLineCurPxlBlue}  = win_q[2][1];
   assign {nextLineNextPxlRed, nextLineNextPxlGreen, nextLineNextPxlBlue} = win_q[2][2];

endmodule

// File: tb/tb_line_window_cache.sv
// Self-checking bench for line_window_cache: directed scenarios followed by
// randomized traffic, compared against a line/pixel reference model.
module tb_line_window_cache;
   logic        pxlClk = 1'b0;
   logic        rst = 1'b1;
   logic        wrEn = 1'b0;
   logic [7:0]  wrAddr = '0;
   logic [14:0] wrData = '0;
   logic        wrLineDone = 1'b0, newFrameIn = 1'b0, nextLine = 1'b0, cacheUpdate = 1'b0;
   logic [7:0]  curPxl = '0;
   logic        sameLine, overrun;
   logic [7:0]  prevLinePrevPxlRed, prevLinePrevPxlGreen, prevLinePrevPxlBlue;
   logic [7:0]  prevLineCurPxlRed,  prevLineCurPxlGreen,  prevLineCurPxlBlue;
   logic [7:0]  prevLineNextPxlRed, prevLineNextPxlGreen, prevLineNextPxlBlue;
   logic [7:0]  curLinePrevPxlRed,  curLinePrevPxlGreen,  curLinePrevPxlBlue;
   logic [7:0]  curLineCurPxlRed,   curLineCurPxlGreen,   curLineCurPxlBlue;
   logic [7:0]  curLineNextPxlRed,  curLineNextPxlGreen,  curLineNextPxlBlue;
   logic [7:0]  nextLinePrevPxlRed, nextLinePrevPxlGreen, nextLinePrevPxlBlue;
   logic [7:0]  nextLineCurPxlRed,  nextLineCurPxlGreen,  nextLineCurPxlBlue;
   logic [7:0]  nextLineNextPxlRed, nextLineNextPxlGreen, nextLineNextPxlBlue;

   line_window_cache dut (
      .pxlClk(pxlClk), .rst(rst), .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
      .wrLineDone(wrLineDone), .newFrameIn(newFrameIn), .curPxl(curPxl),
      .nextLine(nextLine), .cacheUpdate(cacheUpdate), .sameLine(sameLine),
      .prevLinePrevPxlRed(prevLinePrevPxlRed), .prevLinePrevPxlGreen(prevLinePrevPxlGreen),
      .prevLinePrevPxlBlue(prevLinePrevPxlBlue),
      .prevLineCurPxlRed(prevLineCurPxlRed), .prevLineCurPxlGreen(prevLineCurPxlGreen),
      .prevLineCurPxlBlue(prevLineCurPxlBlue),
      .prevLineNextPxlRed(prevLineNextPxlRed), .prevLineNextPxlGreen(prevLineNextPxlGreen),
      .prevLineNextPxlBlue(prevLineNextPxlBlue),
      .curLinePrevPxlRed(curLinePrevPxlRed), .curLinePrevPxlGreen(curLinePrevPxlGreen),
      .curLinePrevPxlBlue(curLinePrevPxlBlue),
      .curLineCurPxlRed(curLineCurPxlRed), .curLineCurPxlGreen(curLineCurPxlGreen),
      .curLineCurPxlBlue(curLineCurPxlBlue),
      .curLineNextPxlRed(curLineNextPxlRed), .curLineNextPxlGreen(curLineNextPxlGreen),
      .curLineNextPxlBlue(curLineNextPxlBlue),
      .nextLinePrevPxlRed(nextLinePrevPxlRed), .nextLinePrevPxlGreen(nextLinePrevPxlGreen),
      .nextLinePrevPxlBlue(nextLinePrevPxlBlue),
      .nextLineCurPxlRed(nextLineCurPxlRed), .nextLineCurPxlGreen(nextLineCurPxlGreen),
      .nextLineCurPxlBlue(nextLineCurPxlBlue),
      .nextLineNextPxlRed(nextLineNextPxlRed), .nextLineNextPxlGreen(nextLineNextPxlGreen),
      .nextLineNextPxlBlue(nextLineNextPxlBlue),
      .overrun(overrun)
   );

   always #5 pxlClk = ~pxlClk;

   logic [215:0] got_win;
   assign got_win = {prevLinePrevPxlRed, prevLinePrevPxlGreen, prevLinePrevPxlBlue,
                     prevLineCurPxlRed,  prevLineCurPxlGreen,  prevLineCurPxlBlue,
                     prevLineNextPxlRed, prevLineNextPxlGreen, prevLineNextPxlBlue,
                     curLinePrevPxlRed,  curLinePrevPxlGreen,  curLinePrevPxlBlue,
                     curLineCurPxlRed,   curLineCurPxlGreen,   curLineCurPxlBlue,
                     curLineNextPxlRed,  curLineNextPxlGreen,  curLineNextPxlBlue,
                     nextLinePrevPxlRed, nextLinePrevPxlGreen, nextLinePrevPxlBlue,
                     nextLineCurPxlRed,  nextLineCurPxlGreen,  nextLineCurPxlBlue,
                     nextLineNextPxlRed, nextLineNextPxlGreen, nextLineNextPxlBlue};

   int n_chk = 0, n_pass = 0;

   // Reference model: per-buffer pixel store plus line counters.
   logic [23:0] mem [4][240];
   bit          vld [4][240];
   int          m_wr = 0, m_done = 0, m_rd = 0;
   bit          m_adv = 0, m_ovr = 0;

   task automatic chk(input string tag, input logic [215:0] obs, input logic [215:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [23:0] exp_px(input logic [14:0] p);
      int r, g, b;
      r = int'(p[14:10]); g = int'(p[9:5]); b = int'(p[4:0]);
      return {8'(r * 8 + r / 4), 8'(g * 8 + g / 4), 8'(b * 8 + b / 4)};
   endfunction

   function automatic int clampi(input int v, input int lo, input int hi);
      return (v < lo) ? lo : (v > hi) ? hi : v;
   endfunction

   function automatic bit exp_same(input int rd, input int done);
      int need;
      need = (rd + 3 < 160) ? rd + 3 : 160;
      return (rd == 159) || (done < need);
   endfunction

   task automatic model_win(input int rd, input int px, output logic [215:0] w, output bit ok);
      int ln, col;
      w = '0; ok = 1;
      for (int r = -1; r <= 1; r++) begin
         ln = clampi(rd + r, 0, 159);
         for (int c = -1; c <= 1; c++) begin
            col = (px >= 240) ? 239 : clampi(px + c, 0, 239);
            w = {w[191:0], mem[ln % 4][col]};
            ok = ok && vld[ln % 4][col];
         end
      end
   endtask

   // Called just after a clock edge while that cycle's inputs are still applied.
   task automatic model_update();
      logic [215:0] ew;
      bit ok, pre_same;
      model_win(m_rd, int'(curPxl), ew, ok);
      pre_same = exp_same(m_rd, m_done);
      if (wrEn && wrAddr < 8'd240) begin
         mem[m_wr % 4][wrAddr] = exp_px(wrData);
         vld[m_wr % 4][wrAddr] = 1;
      end
      if (newFrameIn) begin
         m_wr = 0; m_done = 0; m_rd = 0; m_adv = 0;
      end else begin
         if (wrLineDone) begin
            if (m_wr > m_rd + 2) m_ovr = 1;
            m_done = m_wr + 1;
            m_wr = (m_wr + 1 > 160) ? 160 : m_wr + 1;
         end
         if (cacheUpdate) begin
            if ((m_adv || nextLine) && !pre_same) m_rd++;
            m_adv = 0;
         end else if (nextLine) m_adv = 1;
      end
      chk("sameLine", 216'(sameLine), 216'(exp_same(m_rd, m_done)));
      chk("overrun", 216'(overrun), 216'(m_ovr));
      if (ok) chk("window", got_win, ew);
   endtask

   task automatic cyc(input bit we, input int addr, input logic [14:0] data, input bit done,
                      input bit nf, input bit nl, input bit cu, input int px);
      wrEn = we; wrAddr = 8'(addr); wrData = data; wrLineDone = done;
      newFrameIn = nf; nextLine = nl; cacheUpdate = cu; curPxl = 8'(px);
      @(posedge pxlClk); #1;
      model_update();
   endtask

   task automatic idle(input int px);
      cyc(0, 0, '0, 0, 0, 0, 0, px);
   endtask

   // Reset asserted between edges while a write is being presented.
   task automatic do_reset();
      wrEn = 1; wrAddr = 8'($urandom_range(0, 239)); wrData = 15'($urandom);
      #2 rst = 1'b0;
      #1;
      chk("rst_win", got_win, '0);
      chk("rst_same", 216'(sameLine), 216'(1));
      chk("rst_ovr", 216'(overrun), 216'(0));
      wrEn = 0; wrLineDone = 0; newFrameIn = 0; nextLine = 0; cacheUpdate = 0;
      @(posedge pxlClk); #1;
      chk("rst_hold", got_win, '0);
      rst = 1'b1;
      m_wr = 0; m_done = 0; m_rd = 0; m_adv = 0; m_ovr = 0;
   endtask

   initial begin
      logic [14:0] d;
      int px;
      do_reset();

      // Fill four lines; line 0 carries the expansion pattern at pixels 4..6.
      for (int ln = 0; ln < 4; ln++) begin
         for (int a = 0; a < 240; a++) begin
            d = 15'($urandom);
            if (ln == 0 && a == 4) d = 15'h0000;
            if (ln == 0 && a == 5) d = 15'h7FFF;
            if (ln == 0 && a == 6) d = 15'h001F;
            cyc(1, a, d, 0, 0, 0, 0, $urandom_range(0, 255));
         end
         cyc(0, 0, '0, 1, 0, 0, 0, 5);
         if (ln == 0) begin
            idle(5);
            chk("exp_cur",  216'({curLineCurPxlRed, curLineCurPxlGreen, curLineCurPxlBlue}), 216'(24'hFFFFFF));
            chk("exp_prev", 216'({curLinePrevPxlRed, curLinePrevPxlGreen, curLinePrevPxlBlue}), 216'(24'h000000));
            chk("exp_next", 216'({curLineNextPxlRed, curLineNextPxlGreen, curLineNextPxlBlue}), 216'(24'h0000FF));
         end
         if (ln == 2) chk("same_after3", 216'(sameLine), 216'(0));
         if (ln == 3) chk("ovr_after4", 216'(overrun), 216'(1));
      end

      // Column/row clamps at rdLine 0.
      idle(0);
      chk("clamp0", 216'({prevLinePrevPxlRed, prevLinePrevPxlGreen, prevLinePrevPxlBlue}), 216'(mem[0][0]));
      idle(239);
      chk("clamp239", 216'({curLineNextPxlRed, curLineNextPxlGreen, curLineNextPxlBlue}), 216'(mem[0][239]));
      idle(250);
      chk("clamp250", 216'({nextLinePrevPxlRed, nextLinePrevPxlGreen, nextLinePrevPxlBlue}), 216'(mem[1][239]));

      // Same-cycle nextLine+cacheUpdate with 4 lines done advances to line 1.
      cyc(0, 0, '0, 0, 0, 1, 1, 10);
      idle(10);
      chk("rows012", 216'({prevLineCurPxlRed, prevLineCurPxlGreen, prevLineCurPxlBlue}), 216'(mem[0][10]));

      // New frame with only 3 lines done: second advance is refused.
      idle(10);
      cyc(0, 0, '0, 0, 1, 0, 0, 10);
      chk("ovr_sticky", 216'(overrun), 216'(1));
      for (int i = 0; i < 3; i++) cyc(0, 0, '0, 1, 0, 0, 0, 10);
      chk("same_3done", 216'(sameLine), 216'(0));
      cyc(0, 0, '0, 0, 0, 1, 1, 20);
      chk("same_rd1", 216'(sameLine), 216'(1));
      cyc(0, 0, '0, 0, 0, 1, 0, 20);
      cyc(0, 0, '0, 0, 0, 0, 1, 20);
      chk("same_drop", 216'(sameLine), 216'(1));
      idle(20);
      chk("rd_stays1", 216'({nextLineCurPxlRed, nextLineCurPxlGreen, nextLineCurPxlBlue}), 216'(mem[2][20]));

      // Resync from rdLine 100 with a colliding wrLineDone.
      cyc(0, 0, '0, 0, 1, 0, 0, 30);
      for (int i = 0; i < 160; i++) cyc(0, 0, '0, 1, 0, 0, 0, 30);
      for (int i = 0; i < 100; i++) cyc(0, 0, '0, 0, 0, 1, 1, 30);
      chk("same_rd100", 216'(sameLine), 216'(0));
      cyc(0, 0, '0, 1, 1, 0, 0, 30);
      chk("resync_same", 216'(sameLine), 216'(1));
      idle(30);
      chk("resync_row", 216'({prevLineCurPxlRed, prevLineCurPxlGreen, prevLineCurPxlBlue}), 216'(mem[0][30]));

      // Randomized traffic with one reset in the middle.
      for (int i = 0; i < 4000; i++) begin
         if (i == 2000) do_reset();
         case ($urandom_range(0, 7))
            0:       px = 0;
            1:       px = 239;
            2:       px = $urandom_range(240, 255);
            default: px = $urandom_range(0, 239);
         endcase
         cyc($urandom_range(0, 1) == 1, $urandom_range(0, 255), 15'($urandom),
             $urandom_range(0, 5) == 0, $urandom_range(0, 499) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, px);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
